mult_cmd_scheduler: RTL and testbench

//  Sequencer between the command FIFO and the shared field multiplier. Pops one

---
 rtl/mult_cmd_scheduler_if.sv | 25 ++
 rtl/mult_cmd_scheduler.sv | 146 ++++++++++++++
 tb/tb_mult_cmd_scheduler.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mult_cmd_scheduler_if.sv
// Handshake bundle between the command scheduler, the command FIFO read port
// and the shared field multiplier.
interface mult_cmd_scheduler_if #(
  parameter int CMD_W = 8,
  parameter int SEL_W = 3
);
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [CMD_W-1:0] fifo_data;
  logic             mul_start;
  logic [SEL_W-1:0] mul_sel_a;
  logic [SEL_W-1:0] mul_sel_b;
  logic             mul_square;
  logic             mul_done;

  modport master (
    input  fifo_empty, fifo_data, mul_done,
    output fifo_rd_en, mul_start, mul_sel_a, mul_sel_b, mul_square
  );

  modport slave (
    output fifo_empty, fifo_data, mul_done,
    input  fifo_rd_en, mul_start, mul_sel_a, mul_sel_b, mul_square
  );
endinterface

// File: rtl/mult_cmd_scheduler.sv
// Pops commands from the FIFO, decodes NOP/MUL/SQR/HALT and drives the multiplier.
// Define MULT_SCHED_WATCHDOG_EN to add a mul_done watchdog that halts on timeout.
module mult_cmd_scheduler #(
  parameter int CMD_W   = 8,
  parameter int SEL_W   = 3,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 resume,
  mult_cmd_scheduler_if.master bus,
  output logic                 busy,
  output logic                 halted,
  output logic [CNT_W-1:0]     op_count,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_HALTED
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_SQR  = 2'b10;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_a_q, sel_a_d;
  logic [SEL_W-1:0] sel_b_q, sel_b_d;
  logic             square_q, square_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [1:0]       cmd_op;
  logic [SEL_W-1:0] cmd_a;
  logic [SEL_W-1:0] cmd_b;

  assign cmd_op = bus.fifo_data[2*SEL_W+1 -: 2];
  assign cmd_a  = bus.fifo_data[2*SEL_W-1 -: SEL_W];
  assign cmd_b  = bus.fifo_data[SEL_W-1:0];

`ifdef MULT_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_err_q, timeout_err_d;
  logic            wd_expired;

  // Fires on the WAIT cycle in which the count would reach TIMEOUT.
  assign wd_expired  = (wd_cnt_q == WD_W'(TIMEOUT - 1));
  assign timeout_err = timeout_err_q;
`else
  logic wd_expired;

  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0 & (TIMEOUT > 0);
`endif

  always_comb begin
    state_d    = state_q;
    sel_a_d    = sel_a_q;
    sel_b_d    = sel_b_q;
    square_d   = square_q;
    op_count_d = op_count_q;
    case (state_q)
      S_IDLE:   if (enable && !bus.fifo_empty) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        // Operand selects change only when a real multiply is decoded.
        if (cmd_op == OP_NOP) begin
          state_d = S_IDLE;
        end else if (cmd_op == OP_MUL) begin
          sel_a_d  = cmd_a;
          sel_b_d  = cmd_b;
          square_d = 1'b0;
          state_d  = S_ISSUE;
        end else if (cmd_op == OP_SQR) begin
          sel_a_d  = cmd_a;
          sel_b_d  = cmd_a;
          square_d = 1'b1;
          state_d  = S_ISSUE;
        end else begin
          state_d = S_HALTED;
        end
      end
      S_ISSUE: begin
        op_count_d = op_count_q + 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mul_done)    state_d = S_IDLE;
        else if (wd_expired) state_d = S_HALTED;
      end
      S_HALTED: if (resume) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_a_q    <= '0;
      sel_b_q    <= '0;
      square_q   <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_a_q    <= sel_a_d;
      sel_b_q    <= sel_b_d;
      square_q   <= square_d;
      op_count_q <= op_count_d;
    end
  end

`ifdef MULT_SCHED_WATCHDOG_EN
  always_comb begin
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    if (state_q == S_ISSUE) begin
      wd_cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (!bus.mul_done && wd_expired) timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
`endif

  assign bus.fifo_rd_en = (state_q == S_FETCH);
  assign bus.mul_start  = (state_q == S_ISSUE);
  assign bus.mul_sel_a  = sel_a_q;
  assign bus.mul_sel_b  = sel_b_q;
  assign bus.mul_square = square_q;
  assign busy           = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted         = (state_q == S_HALTED);
  assign op_count       = op_count_q;

endmodule

// File: tb/tb_mult_cmd_scheduler.sv
// Self-checking bench: the bench plays the FIFO and multiplier and checks the
// scheduler against a per-command timing/selection model.
module tb_mult_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       resume;
  logic       busy;
  logic       halted;
  logic       timeout_err;
  logic [7:0] op_count;

  mult_cmd_scheduler_if #(.CMD_W(8), .SEL_W(3)) bus ();

  mult_cmd_scheduler #(
    .CMD_W(8), .SEL_W(3), .CNT_W(8), .TIMEOUT(10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .resume      (resume),
    .bus         (bus.master),
    .busy        (busy),
    .halted      (halted),
    .op_count    (op_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] fifo_q[$];
  int         exp_count = 0;
  logic [2:0] exp_a = '0;
  logic [2:0] exp_b = '0;
  logic       exp_sq = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance to the next falling edge, acting as the FIFO and clearing pulses.
  task automatic step();
    @(negedge clk);
    if (bus.fifo_rd_en && fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.mul_done   = 1'b0;
    resume         = 1'b0;
  endtask

  task automatic push(input logic [7:0] cmd);
    fifo_q.push_back(cmd);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_sel_a"}, 32'(bus.mul_sel_a), 32'(exp_a));
    if (!exp_sq) chk({tag, "_sel_b"}, 32'(bus.mul_sel_b), 32'(exp_b));
    chk({tag, "_square"}, 32'(bus.mul_square), 32'(exp_sq));
    chk({tag, "_op_count"}, 32'(op_count), 32'(exp_count % 256));
  endtask

  // One command from an IDLE start: FETCH, DECODE, then the opcode's outcome.
  task automatic run_op(input logic [7:0] cmd, input int dly, input bit do_push, input bit early_done);
    logic [1:0] op;
    op = cmd[7:6];
    if (do_push) push(cmd);
    step();
    chk("fetch_rd_en", 32'(bus.fifo_rd_en), 1);
    chk("fetch_busy", 32'(busy), 1);
    step();
    chk("decode_rd_en", 32'(bus.fifo_rd_en), 0);
    chk("decode_start", 32'(bus.mul_start), 0);
    step();
    if (op == 2'b01 || op == 2'b10) begin
      exp_a  = cmd[5:3];
      exp_b  = (op == 2'b10) ? cmd[5:3] : cmd[2:0];
      exp_sq = (op == 2'b10);
      chk("issue_start", 32'(bus.mul_start), 1);
      chk_regs("issue");
      exp_count++;
      if (early_done) bus.mul_done = 1'b1;
      step();
      chk("wait_busy", 32'(busy), 1);
      chk("wait_start", 32'(bus.mul_start), 0);
      chk("wait_op_count", 32'(op_count), 32'(exp_count % 256));
      for (int i = 0; i < dly; i++) begin
        if (i == 1) resume = 1'b1;
        step();
        chk("wait_hold_busy", 32'(busy), 1);
      end
      bus.mul_done = 1'b1;
      step();
      chk("done_busy", 32'(busy), 0);
      chk("done_halted", 32'(halted), 0);
      chk_regs("done");
    end else if (op == 2'b00) begin
      chk("nop_start", 32'(bus.mul_start), 0);
      chk("nop_busy", 32'(busy), 0);
      chk_regs("nop");
    end else begin
      chk("halt_halted", 32'(halted), 1);
      chk("halt_busy", 32'(busy), 0);
      chk("halt_start", 32'(bus.mul_start), 0);
    end
  endtask

  task automatic stay_halted_then_resume(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("halted_hold", 32'(halted), 1);
      chk("halted_no_fetch", 32'(bus.fifo_rd_en), 0);
    end
    resume = 1'b1;
    step();
    chk("resume_halted", 32'(halted), 0);
    chk("resume_busy", 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(bus.mul_start), 0);
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    exp_count = 0; exp_a = '0; exp_b = '0; exp_sq = 1'b0;
    chk_regs("rst");
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] cmd;
    rst = 1'b1; enable = 1'b0; resume = 1'b0;
    bus.fifo_empty = 1'b1; bus.fifo_data = '0; bus.mul_done = 1'b0;
    step();
    do_reset();
    enable = 1'b1;

    // MUL A=1 B=2, then back-to-back SQR A=3 and MUL with early done ignored
    run_op(8'h4A, 2, 1'b1, 1'b0);
    chk("t1_op_count", 32'(op_count), 1);
    push(8'h98); push(8'h6C);
    run_op(8'h98, 5, 1'b0, 1'b0);
    run_op(8'h6C, 3, 1'b0, 1'b1);

    // enable low gates fetching
    enable = 1'b0;
    push(8'h51);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("disabled_rd_en", 32'(bus.fifo_rd_en), 0);
    end
    enable = 1'b1;
    run_op(8'h51, 1, 1'b0, 1'b0);

    // NOP, HALT, MUL: halt blocks fetch until resume
    push(8'h00); push(8'hC0); push(8'h63);
    run_op(8'h00, 0, 1'b0, 1'b0);
    run_op(8'hC0, 0, 1'b0, 1'b0);
    stay_halted_then_resume(20);
    run_op(8'h63, 2, 1'b0, 1'b0);

    // reset while waiting; the stale done must be ignored
    push(8'h4A);
    step(); step(); step(); step();
    chk("pre_rst_busy", 32'(busy), 1);
    do_reset();
    bus.mul_done = 1'b1;
    step();
    chk("stale_done_busy", 32'(busy), 0);
    chk("stale_done_op_count", 32'(op_count), 0);

    // 256 operations wrap the counter back to zero
    for (int i = 0; i < 256; i++) begin
      cmd = {2'b01, 6'($urandom_range(0, 63))};
      run_op(cmd, $urandom_range(0, 2), 1'b1, 1'b0);
    end
    chk("wrap_op_count", 32'(op_count), 0);

    // empty FIFO: no fetch
    for (int i = 0; i < 10; i++) begin
      step();
      chk("empty_rd_en", 32'(bus.fifo_rd_en), 0);
      chk("empty_busy", 32'(busy), 0);
    end

    // random mix
    for (int i = 0; i < 60; i++) begin
      cmd = 8'($urandom);
      if (cmd[7:6] == 2'b11 && $urandom_range(0, 2) != 0) cmd[7:6] = 2'b01;
      run_op(cmd, $urandom_range(0, 6), 1'b1, 1'($urandom_range(0, 1)));
      if (cmd[7:6] == 2'b11) stay_halted_then_resume($urandom_range(1, 5));
    end

    // missing mul_done
    push(8'h4A);
    step(); step(); step();
    chk("wd_start", 32'(bus.mul_start), 1);
    exp_count++;
`ifdef MULT_SCHED_WATCHDOG_EN
    for (int i = 0; i < 10; i++) step();
    chk("wd_not_yet", 32'(timeout_err), 0);
    step();
    chk("wd_timeout_err", 32'(timeout_err), 1);
    chk("wd_halted", 32'(halted), 1);
`else
    for (int i = 0; i < 30; i++) begin
      step();
      chk("nowd_busy", 32'(busy), 1);
      chk("nowd_timeout_err", 32'(timeout_err), 0);
    end
    bus.mul_done = 1'b1;
    step();
    chk("nowd_done_busy", 32'(busy), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
